alarm_arm_sequencer: RTL and testbench

//  Arming/alarm controller for the intruder-alarm VGA display design.

---
 rtl/alarm_arm_sequencer_pkg.sv | 17 +
 rtl/alarm_arm_sequencer_if.sv | 27 ++
 rtl/alarm_arm_sequencer_sensor_debounce.sv | 45 ++++
 rtl/alarm_arm_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alarm_arm_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alarm_arm_sequencer_pkg.sv
// Shared definitions for the arming/alarm sequencer: state codes and zone bit positions.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4,
        ST_SILENCED    = 3'd5
    } state_t;

    localparam int ZONE_DOOR   = 0;
    localparam int ZONE_WINDOW = 1;
    localparam int ZONE_MOTION = 2;

endpackage

// File: rtl/alarm_arm_sequencer_if.sv
// User/sensor inputs and display-side outputs of the arming sequencer.
interface alarm_arm_sequencer_if;

    logic       ena;
    logic       arm_req;
    logic       manual_reset;
    logic       door;
    logic       window;
    logic       motion;
    logic [2:0] state;
    logic       alarm_active;
    logic       warn;
    logic [7:0] countdown;
    logic [2:0] zones;
    logic       arm_fault;

    modport master (
        output ena, arm_req, manual_reset, door, window, motion,
        input  state, alarm_active, warn, countdown, zones, arm_fault
    );

    modport slave (
        input  ena, arm_req, manual_reset, door, window, motion,
        output state, alarm_active, warn, countdown, zones, arm_fault
    );

endinterface

// File: rtl/alarm_arm_sequencer_sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-high debouncer with rise detect.
module sensor_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic trip,
    output logic trip_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_1;
    logic          sync_2;
    logic          trip_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            trip_d <= 1'b0;
            trip   <= 1'b0;
            cnt    <= '0;
        end else if (ena) begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            trip_d <= trip;
            if (!sync_2) begin
                cnt  <= '0;
                trip <= 1'b0;
            end else if (!trip) begin
                // the sample that completes the run sets trip directly
                if (cnt == CNT_LAST) trip <= 1'b1;
                else                 cnt  <= cnt + CW'(1);
            end
        end
    end

    assign trip_rise = trip & ~trip_d;

endmodule

// File: rtl/alarm_arm_sequencer.sv
// Arming/alarm sequencer: prescaler, state machine, countdown and zone latch.
//  state          | meaning
//  ST_DISARMED    | idle, waiting for arm_req with all zones quiet
//  ST_EXIT_DELAY  | leaving the premises, zones ignored, counting down
//  ST_ARMED       | watching all zones
//  ST_ENTRY_DELAY | door opened, counting down to alarm
//  ST_ALARM       | alarm sounding, counting down to auto-silence
//  ST_SILENCED    | alarm timed out, zones held, re-trigger on any new trip
module alarm_arm_sequencer
    import alarm_pkg::*;
#(
    parameter int TICK_DIV        = 25_000_000,
    parameter int EXIT_DELAY_S    = 10,
    parameter int ENTRY_DELAY_S   = 8,
    parameter int ALARM_TIMEOUT_S = 120,
    parameter int DEBOUNCE_CYC    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alarm_arm_sequencer_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] EXIT_LD    = 8'(EXIT_DELAY_S);
    localparam logic [7:0] ENTRY_LD   = 8'(ENTRY_DELAY_S);
    localparam logic [7:0] TIMEOUT_LD = 8'(ALARM_TIMEOUT_S);

    logic [2:0]    trip, trip_rise;
    state_t        state_q, state_nx;
    logic [PW-1:0] presc_q, presc_nx;
    logic [7:0]    cnt_q, cnt_nx;
    logic [2:0]    zones_q, zones_nx;
    logic          warn_q, warn_nx;
    logic          alarm_q, fault_q, fault_nx;
    logic          arm_req_q;
    logic          tick, instant, arm_rise;

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_door (
        .clk(clk), .rst_n(rst_n), .ena(bus.ena), .raw(bus.door),
        .trip(trip[ZONE_DOOR]), .trip_rise(trip_rise[ZONE_DOOR]));
    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_window (
        .clk(clk), .rst_n(rst_n), .ena(bus.ena), .raw(bus.window),
        .trip(trip[ZONE_WINDOW]), .trip_rise(trip_rise[ZONE_WINDOW]));
    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_motion (
        .clk(clk), .rst_n(rst_n), .ena(bus.ena), .raw(bus.motion),
        .trip(trip[ZONE_MOTION]), .trip_rise(trip_rise[ZONE_MOTION]));

    assign tick     = (presc_q == PRESC_MAX);
    assign instant  = trip[ZONE_WINDOW] | trip[ZONE_MOTION];
    assign arm_rise = bus.arm_req & ~arm_req_q;

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        zones_nx = zones_q;
        warn_nx  = warn_q;
        fault_nx = 1'b0;
        if (bus.manual_reset || !bus.arm_req) begin
            state_nx = ST_DISARMED;
            cnt_nx   = 8'd0;
            zones_nx = 3'b000;
            warn_nx  = 1'b0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (|trip) begin
                        fault_nx = arm_rise;
                    end else begin
                        state_nx = ST_EXIT_DELAY;
                        cnt_nx   = EXIT_LD;
                        warn_nx  = 1'b1;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (tick) begin
                        warn_nx = ~warn_q;
                        if (cnt_q <= 8'd1) begin
                            state_nx = ST_ARMED;
                            cnt_nx   = 8'd0;
                            warn_nx  = 1'b0;
                        end else begin
                            cnt_nx = cnt_q - 8'd1;
                        end
                    end
                end
                ST_ARMED: begin
                    zones_nx = zones_q | trip;
                    if (instant) begin
                        state_nx = ST_ALARM;
                        cnt_nx   = TIMEOUT_LD;
                    end else if (trip[ZONE_DOOR]) begin
                        state_nx = ST_ENTRY_DELAY;
                        cnt_nx   = ENTRY_LD;
                        warn_nx  = 1'b1;
                    end
                end
                ST_ENTRY_DELAY: begin
                    zones_nx = zones_q | trip;
                    if (instant || (tick && cnt_q <= 8'd1)) begin
                        state_nx = ST_ALARM;
                        cnt_nx   = TIMEOUT_LD;
                        warn_nx  = 1'b0;
                    end else if (tick) begin
                        warn_nx = ~warn_q;
                        cnt_nx  = cnt_q - 8'd1;
                    end
                end
                ST_ALARM: begin
                    zones_nx = zones_q | trip;
                    if (tick) begin
                        if (cnt_q <= 8'd1) begin
                            state_nx = ST_SILENCED;
                            cnt_nx   = 8'd0;
                        end else begin
                            cnt_nx = cnt_q - 8'd1;
                        end
                    end
                end
                ST_SILENCED: begin
                    zones_nx = zones_q | trip;
                    if (|trip_rise) begin
                        state_nx = ST_ALARM;
                        cnt_nx   = TIMEOUT_LD;
                    end
                end
                default: begin
                    state_nx = ST_DISARMED;
                    cnt_nx   = 8'd0;
                    zones_nx = 3'b000;
                    warn_nx  = 1'b0;
                end
            endcase
        end
        // timebase restarts with every state so each delay is a whole number of ticks
        if (state_nx != state_q || tick) presc_nx = '0;
        else                             presc_nx = presc_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DISARMED;
            presc_q   <= '0;
            cnt_q     <= 8'd0;
            zones_q   <= 3'b000;
            warn_q    <= 1'b0;
            alarm_q   <= 1'b0;
            fault_q   <= 1'b0;
            arm_req_q <= 1'b0;
        end else if (bus.ena) begin
            state_q   <= state_nx;
            presc_q   <= presc_nx;
            cnt_q     <= cnt_nx;
            zones_q   <= zones_nx;
            warn_q    <= warn_nx;
            alarm_q   <= (state_nx == ST_ALARM);
            fault_q   <= fault_nx;
            arm_req_q <= bus.arm_req;
        end
    end

    assign bus.state        = state_q;
    assign bus.alarm_active = alarm_q;
    assign bus.warn         = warn_q;
    assign bus.countdown    = cnt_q;
    assign bus.zones        = zones_q;
    assign bus.arm_fault    = fault_q;

endmodule

// File: tb/tb_alarm_arm_sequencer.sv
// Directed bench for alarm_arm_sequencer with small timing parameters.
module tb_alarm_arm_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alarm_arm_sequencer_if bus ();

    alarm_arm_sequencer #(
        .TICK_DIV(4), .EXIT_DELAY_S(2), .ENTRY_DELAY_S(3),
        .ALARM_TIMEOUT_S(5), .DEBOUNCE_CYC(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic al,
                           input logic wr, input logic [7:0] cd, input logic [2:0] zn,
                           input logic fl);
        chk({tag, ".state"},     {29'd0, bus.state}, {29'd0, st});
        chk({tag, ".alarm"},     {31'd0, bus.alarm_active}, {31'd0, al});
        chk({tag, ".warn"},      {31'd0, bus.warn}, {31'd0, wr});
        chk({tag, ".countdown"}, {24'd0, bus.countdown}, {24'd0, cd});
        chk({tag, ".zones"},     {29'd0, bus.zones}, {29'd0, zn});
        chk({tag, ".arm_fault"}, {31'd0, bus.arm_fault}, {31'd0, fl});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.arm_req = 1'b0;
        bus.manual_reset = 1'b0;
        bus.door = 1'b0;
        bus.window = 1'b0;
        bus.motion = 1'b0;
        cyc(2);
        chk_all("reset", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        rst_n = 1'b1;
        cyc(3);
        chk_all("idle", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);

        // 1: exit delay, two ticks of four cycles
        bus.arm_req = 1'b1;
        cyc(1);
        chk_all("exit_entry", 3'd1, 1'b0, 1'b1, 8'd2, 3'b000, 1'b0);
        cyc(3);
        chk_all("exit_pre_tick", 3'd1, 1'b0, 1'b1, 8'd2, 3'b000, 1'b0);
        cyc(1);
        chk_all("exit_tick1", 3'd1, 1'b0, 1'b0, 8'd1, 3'b000, 1'b0);
        cyc(3);
        chk("exit_pre_armed.state", {29'd0, bus.state}, 32'd1);
        cyc(1);
        chk_all("armed", 3'd2, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);

        // 2: door held -> entry delay -> alarm
        bus.door = 1'b1;
        cyc(5);
        chk("door_debouncing.state", {29'd0, bus.state}, 32'd2);
        cyc(1);
        chk_all("entry", 3'd3, 1'b0, 1'b1, 8'd3, 3'b001, 1'b0);
        cyc(4);
        chk_all("entry_tick1", 3'd3, 1'b0, 1'b0, 8'd2, 3'b001, 1'b0);
        cyc(7);
        chk_all("entry_last", 3'd3, 1'b0, 1'b1, 8'd1, 3'b001, 1'b0);
        cyc(1);
        chk_all("entry_alarm", 3'd4, 1'b1, 1'b0, 8'd5, 3'b001, 1'b0);

        bus.door = 1'b0;
        bus.arm_req = 1'b0;
        cyc(1);
        chk_all("disarm1", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        cyc(4);
        bus.arm_req = 1'b1;
        cyc(9);
        chk("rearm1.state", {29'd0, bus.state}, 32'd2);

        // 3: short motion glitch rejected, long one trips
        bus.motion = 1'b1;
        cyc(2);
        bus.motion = 1'b0;
        cyc(8);
        chk_all("glitch", 3'd2, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        bus.motion = 1'b1;
        cyc(6);
        bus.motion = 1'b0;
        chk_all("motion_alarm", 3'd4, 1'b1, 1'b0, 8'd5, 3'b100, 1'b0);

        // 4: auto-silence after five ticks, window re-triggers
        cyc(19);
        chk_all("alarm_last", 3'd4, 1'b1, 1'b0, 8'd1, 3'b100, 1'b0);
        cyc(1);
        chk_all("silenced", 3'd5, 1'b0, 1'b0, 8'd0, 3'b100, 1'b0);
        bus.window = 1'b1;
        cyc(5);
        chk("sil_debouncing.state", {29'd0, bus.state}, 32'd5);
        cyc(1);
        chk_all("retrigger", 3'd4, 1'b1, 1'b0, 8'd5, 3'b110, 1'b0);

        // 5: arm refused while window tripped, single fault pulse
        bus.arm_req = 1'b0;
        cyc(1);
        chk_all("disarm2", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        cyc(2);
        bus.arm_req = 1'b1;
        cyc(1);
        chk_all("fault_pulse", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b1);
        cyc(1);
        chk_all("fault_gone", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        cyc(4);
        chk_all("fault_held", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        bus.window = 1'b0;
        cyc(3);
        chk("window_clearing.state", {29'd0, bus.state}, 32'd0);
        cyc(1);
        chk_all("arm_after_clear", 3'd1, 1'b0, 1'b1, 8'd2, 3'b000, 1'b0);
        cyc(8);
        chk("armed3.state", {29'd0, bus.state}, 32'd2);

        // 6: manual reset mid entry delay, then async reset mid alarm
        bus.door = 1'b1;
        cyc(6);
        chk_all("entry2", 3'd3, 1'b0, 1'b1, 8'd3, 3'b001, 1'b0);
        cyc(5);
        chk_all("entry2_mid", 3'd3, 1'b0, 1'b0, 8'd2, 3'b001, 1'b0);
        bus.manual_reset = 1'b1;
        cyc(1);
        chk_all("manual_reset", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        bus.manual_reset = 1'b0;
        bus.door = 1'b0;
        cyc(4);
        chk("rearm4.state", {29'd0, bus.state}, 32'd1);
        cyc(8);
        chk("armed4.state", {29'd0, bus.state}, 32'd2);
        bus.window = 1'b1;
        cyc(6);
        chk_all("window_alarm", 3'd4, 1'b1, 1'b0, 8'd5, 3'b010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);
        bus.window = 1'b0;
        bus.arm_req = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk_all("post_reset", 3'd0, 1'b0, 1'b0, 8'd0, 3'b000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
